// File: rtl/wt_dcache_rd_miss_unit_if.sv
// Miss-request handshake between the per-port read controllers (master) and the read-miss unit (slave).
interface wt_dcache_rd_miss_unit_if #(
  parameter int unsigned NumPorts = 3,
  parameter int unsigned Plen     = 32,
  parameter int unsigned SetAssoc = 4
);
  logic [NumPorts-1:0]               req;
  logic [NumPorts-1:0]               ack;
  logic [NumPorts-1:0]               replay;
  logic [NumPorts-1:0]               rtrn_vld;
  logic [NumPorts-1:0][Plen-1:0]     paddr;
  logic [NumPorts-1:0]               nc;
  logic [NumPorts-1:0][2:0]          size;
  logic [NumPorts-1:0][SetAssoc-1:0] vld_bits;

  modport master (
    output req, paddr, nc, size, vld_bits,
    input  ack, replay, rtrn_vld
  );

  modport slave (
    input  req, paddr, nc, size, vld_bits,
    output ack, replay, rtrn_vld
  );
endinterface

// File: rtl/wt_dcache_rd_miss_unit.sv
// Write-through dcache read-miss unit: round-robin arbitration, single MSHR, memory read and line fill.
// Optional performance counters are built when WT_DCACHE_MISS_PERF_EN is defined.
module wt_dcache_rd_miss_unit #(
  parameter int unsigned NumPorts     = 3,
  parameter int unsigned RdTxId       = 1,
  parameter logic [7:0]  LfsrSeed     = 8'hA5,
  parameter int unsigned Plen         = 32,
  parameter int unsigned SetAssoc     = 4,
  parameter int unsigned LineWidth    = 256,
  parameter int unsigned ClIdxWidth   = 8,
  parameter int unsigned CacheIdWidth = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  wt_dcache_rd_miss_unit_if.slave       miss_if,
  output logic                          mem_req_o,
  input  logic                          mem_ack_i,
  output logic [Plen-1:0]               mem_paddr_o,
  output logic [2:0]                    mem_size_o,
  output logic                          mem_nc_o,
  output logic [CacheIdWidth-1:0]       mem_id_o,
  input  logic                          mem_rtrn_vld_i,
  input  logic [CacheIdWidth-1:0]       mem_rtrn_id_i,
  input  logic [LineWidth-1:0]          mem_rtrn_data_i,
  output logic                          wr_cl_vld_o,
  output logic [Plen-ClIdxWidth-$clog2(LineWidth/8)-1:0] wr_cl_tag_o,
  output logic [ClIdxWidth-1:0]         wr_cl_idx_o,
  output logic [SetAssoc-1:0]           wr_cl_way_o,
  output logic [LineWidth-1:0]          wr_cl_data_o,
  output logic [31:0]                   miss_cnt_o,
  output logic [31:0]                   replay_cnt_o
);

  localparam int unsigned OffsetWidth   = $clog2(LineWidth/8);
  localparam int unsigned TagWidth      = Plen - ClIdxWidth - OffsetWidth;
  localparam int unsigned LineAddrWidth = Plen - OffsetWidth;
  localparam int unsigned PortW         = (NumPorts > 1) ? $clog2(NumPorts) : 1;
  localparam int unsigned WayW          = (SetAssoc > 1) ? $clog2(SetAssoc) : 1;
  localparam logic [CacheIdWidth-1:0] RdId = CacheIdWidth'(RdTxId);

  typedef enum logic {IDLE, WAIT_RTRN} state_e;

  state_e                   state_q;
  logic [PortW-1:0]         rr_q, rr_d;
  logic [PortW-1:0]         owner_q;
  logic [LineAddrWidth-1:0] mshr_line_q;
  logic                     mshr_nc_q;
  logic [SetAssoc-1:0]      mshr_way_q;
  logic [7:0]               lfsr_q, lfsr_d;

  logic                     gnt_vld;
  logic [PortW-1:0]         gnt_idx;
  logic [Plen-1:0]          gnt_paddr;
  logic                     gnt_nc;
  logic [2:0]               gnt_size;
  logic [SetAssoc-1:0]      gnt_way;
  logic [WayW-1:0]          way_idx;
  logic                     free_found;
  logic                     grant_fire;
  logic                     rtrn_fire;

  // Round-robin: first requester at or above the pointer, else wrap to the lowest requester.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int unsigned i = 0; i < NumPorts; i++) begin
      if (!gnt_vld && miss_if.req[i] && (i >= 32'(rr_q))) begin
        gnt_vld = 1'b1;
        gnt_idx = PortW'(i);
      end
    end
    for (int unsigned i = 0; i < NumPorts; i++) begin
      if (!gnt_vld && miss_if.req[i]) begin
        gnt_vld = 1'b1;
        gnt_idx = PortW'(i);
      end
    end
    rr_d = (32'(gnt_idx) == NumPorts - 1) ? '0 : gnt_idx + PortW'(1);
  end

  assign gnt_paddr = miss_if.paddr[gnt_idx];
  assign gnt_nc    = miss_if.nc[gnt_idx];
  assign gnt_size  = miss_if.size[gnt_idx];

  // Victim: lowest invalid way, otherwise a pseudo-random way from the LFSR.
  always_comb begin
    free_found = 1'b0;
    way_idx    = lfsr_q[WayW-1:0];
    for (int unsigned i = 0; i < SetAssoc; i++) begin
      if (!free_found && !miss_if.vld_bits[gnt_idx][i]) begin
        free_found = 1'b1;
        way_idx    = WayW'(i);
      end
    end
    gnt_way = SetAssoc'(1) << way_idx;
    lfsr_d  = {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? 8'hB8 : 8'h00);
  end

  assign mem_req_o  = rst_ni && (state_q == IDLE) && gnt_vld;
  assign grant_fire = mem_req_o && mem_ack_i;
  assign rtrn_fire  = rst_ni && (state_q == WAIT_RTRN) && mem_rtrn_vld_i && (mem_rtrn_id_i == RdId);

  assign mem_paddr_o = !mem_req_o ? '0 :
                       gnt_nc     ? gnt_paddr :
                                    {gnt_paddr[Plen-1:OffsetWidth], {OffsetWidth{1'b0}}};
  assign mem_size_o  = !mem_req_o ? 3'b000 : (gnt_nc ? gnt_size : 3'b111);
  assign mem_nc_o    = mem_req_o && gnt_nc;
  assign mem_id_o    = rst_ni ? RdId : '0;

  // Per-port handshake strobes; replay flags any request hitting the in-flight line.
  always_comb begin
    miss_if.ack      = '0;
    miss_if.replay   = '0;
    miss_if.rtrn_vld = '0;
    if (grant_fire) miss_if.ack = NumPorts'(1) << gnt_idx;
    if (rtrn_fire)  miss_if.rtrn_vld = NumPorts'(1) << owner_q;
    for (int unsigned i = 0; i < NumPorts; i++) begin
      miss_if.replay[i] = rst_ni && (state_q == WAIT_RTRN) && miss_if.req[i] &&
                          (miss_if.paddr[i][Plen-1:OffsetWidth] == mshr_line_q);
    end
  end

  assign wr_cl_vld_o  = rtrn_fire && !mshr_nc_q;
  assign wr_cl_tag_o  = wr_cl_vld_o ? mshr_line_q[LineAddrWidth-1 -: TagWidth] : '0;
  assign wr_cl_idx_o  = wr_cl_vld_o ? mshr_line_q[ClIdxWidth-1:0] : '0;
  assign wr_cl_way_o  = wr_cl_vld_o ? mshr_way_q : '0;
  assign wr_cl_data_o = rst_ni ? mem_rtrn_data_i : '0;

  // FSM, MSHR, arbitration pointer and replacement LFSR.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      rr_q        <= '0;
      owner_q     <= '0;
      mshr_line_q <= '0;
      mshr_nc_q   <= 1'b0;
      mshr_way_q  <= '0;
      lfsr_q      <= LfsrSeed;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_fire) begin
            state_q     <= WAIT_RTRN;
            rr_q        <= rr_d;
            owner_q     <= gnt_idx;
            mshr_line_q <= gnt_paddr[Plen-1:OffsetWidth];
            mshr_nc_q   <= gnt_nc;
            mshr_way_q  <= gnt_way;
            if (!gnt_nc) lfsr_q <= lfsr_d;
          end
        end
        WAIT_RTRN: begin
          if (rtrn_fire) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef WT_DCACHE_MISS_PERF_EN
  logic [31:0] miss_cnt_q, replay_cnt_q;

  // Saturating grant and replay-cycle counters.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      miss_cnt_q   <= '0;
      replay_cnt_q <= '0;
    end else begin
      if (grant_fire && (miss_cnt_q != 32'hFFFF_FFFF)) miss_cnt_q <= miss_cnt_q + 32'd1;
      if ((|miss_if.replay) && (replay_cnt_q != 32'hFFFF_FFFF)) replay_cnt_q <= replay_cnt_q + 32'd1;
    end
  end

  assign miss_cnt_o   = miss_cnt_q;
  assign replay_cnt_o = replay_cnt_q;
`else
  assign miss_cnt_o   = '0;
  assign replay_cnt_o = '0;
`endif

endmodule

// File: tb/tb_wt_dcache_rd_miss_unit.sv
// Directed self-checking bench for wt_dcache_rd_miss_unit (3 ports, 4 ways, 32-byte lines).
module tb_wt_dcache_rd_miss_unit;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         mem_ack;
  logic         mem_req;
  logic [31:0]  mem_paddr;
  logic [2:0]   mem_size;
  logic         mem_nc;
  logic [1:0]   mem_id;
  logic         rtrn_vld;
  logic [1:0]   rtrn_id;
  logic [255:0] rtrn_data;
  logic         wr_vld;
  logic [18:0]  wr_tag;
  logic [7:0]   wr_idx;
  logic [3:0]   wr_way;
  logic [255:0] wr_data;
  logic [31:0]  miss_cnt;
  logic [31:0]  replay_cnt;

  int n_chk  = 0;
  int n_pass = 0;

`ifdef WT_DCACHE_MISS_PERF_EN
  localparam bit PerfEn = 1'b1;
`else
  localparam bit PerfEn = 1'b0;
`endif

  wt_dcache_rd_miss_unit_if #(.NumPorts(3), .Plen(32), .SetAssoc(4)) mif ();

  wt_dcache_rd_miss_unit dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .miss_if         (mif),
    .mem_req_o       (mem_req),
    .mem_ack_i       (mem_ack),
    .mem_paddr_o     (mem_paddr),
    .mem_size_o      (mem_size),
    .mem_nc_o        (mem_nc),
    .mem_id_o        (mem_id),
    .mem_rtrn_vld_i  (rtrn_vld),
    .mem_rtrn_id_i   (rtrn_id),
    .mem_rtrn_data_i (rtrn_data),
    .wr_cl_vld_o     (wr_vld),
    .wr_cl_tag_o     (wr_tag),
    .wr_cl_idx_o     (wr_idx),
    .wr_cl_way_o     (wr_way),
    .wr_cl_data_o    (wr_data),
    .miss_cnt_o      (miss_cnt),
    .replay_cnt_o    (replay_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic clr_inputs();
    mif.req = '0; mif.paddr = '0; mif.nc = '0; mif.size = '0; mif.vld_bits = '0;
    mem_ack = 1'b0; rtrn_vld = 1'b0; rtrn_id = 2'd0; rtrn_data = '0;
  endtask

  task automatic set_port(input int p, input logic [31:0] a, input logic nc,
                          input logic [2:0] sz, input logic [3:0] vb);
    mif.paddr[p] = a; mif.nc[p] = nc; mif.size[p] = sz; mif.vld_bits[p] = vb; mif.req[p] = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk); clr_inputs(); rst_n = 1'b0;
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk); clr_inputs(); rst_n = 1'b0;
    @(negedge clk);
    set_port(0, 32'h8000_1040, 1'b0, 3'd0, 4'b0000);
    mem_ack = 1'b1; rtrn_vld = 1'b1; rtrn_id = 2'd1;
    @(negedge clk); #1;
    n_chk++; if (mem_req !== 1'b0) $display("FAIL rst_mem_req got=%b exp=0", mem_req); else n_pass++;
    n_chk++; if (mif.ack !== 3'b000) $display("FAIL rst_ack got=%b exp=000", mif.ack); else n_pass++;
    n_chk++; if (mif.rtrn_vld !== 3'b000 || wr_vld !== 1'b0)
      $display("FAIL rst_rtrn got=%b/%b exp=000/0", mif.rtrn_vld, wr_vld); else n_pass++;
    n_chk++; if (mem_id !== 2'd0) $display("FAIL rst_mem_id got=%0d exp=0", mem_id); else n_pass++;
    n_chk++; if (miss_cnt !== 32'd0 || replay_cnt !== 32'd0)
      $display("FAIL rst_cnt got=%0d/%0d exp=0/0", miss_cnt, replay_cnt); else n_pass++;
    clr_inputs(); rst_n = 1'b1;
  endtask

  task automatic test_basic();
    do_reset();
    set_port(0, 32'h8000_1040, 1'b0, 3'd0, 4'b0011); mem_ack = 1'b1; #1;
    n_chk++; if (mif.ack !== 3'b001) $display("FAIL basic_ack got=%b exp=001", mif.ack); else n_pass++;
    n_chk++; if (mem_req !== 1'b1 || mem_paddr !== 32'h8000_1040 || mem_size !== 3'b111 || mem_nc !== 1'b0)
      $display("FAIL basic_mem got=%b %h %b %b exp=1 80001040 111 0", mem_req, mem_paddr, mem_size, mem_nc);
    else n_pass++;
    n_chk++; if (mem_id !== 2'd1) $display("FAIL basic_mem_id got=%0d exp=1", mem_id); else n_pass++;
    @(negedge clk); mif.req = '0; mem_ack = 1'b0; #1;
    n_chk++; if (mem_req !== 1'b0 || mif.rtrn_vld !== 3'b000)
      $display("FAIL basic_wait got=%b/%b exp=0/000", mem_req, mif.rtrn_vld); else n_pass++;
    @(negedge clk); rtrn_vld = 1'b1; rtrn_id = 2'd1; rtrn_data = {8{32'hCAFE_F00D}}; #1;
    n_chk++; if (mif.rtrn_vld !== 3'b001) $display("FAIL basic_rtrn got=%b exp=001", mif.rtrn_vld); else n_pass++;
    n_chk++; if (wr_vld !== 1'b1 || wr_way !== 4'b0100)
      $display("FAIL basic_wr got=%b way=%b exp=1 way=0100", wr_vld, wr_way); else n_pass++;
    n_chk++; if (wr_tag !== 19'h40000 || wr_idx !== 8'h82)
      $display("FAIL basic_tagidx got=%h/%h exp=40000/82", wr_tag, wr_idx); else n_pass++;
    n_chk++; if (wr_data !== {8{32'hCAFE_F00D}}) $display("FAIL basic_data got=%h", wr_data); else n_pass++;
    @(negedge clk); clr_inputs(); #1;
    n_chk++; if (mif.rtrn_vld !== 3'b000 || wr_vld !== 1'b0)
      $display("FAIL basic_idle got=%b/%b exp=000/0", mif.rtrn_vld, wr_vld); else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [31:0] exp_pa;
    do_reset();
    for (int p = 0; p < 3; p++) set_port(p, 32'h8000_0004 + 32'(p) * 32'h100, 1'b0, 3'd0, 4'b0000);
    mem_ack = 1'b1;
    for (int k = 0; k < 3; k++) begin
      exp_pa = 32'h8000_0000 + 32'(k) * 32'h100;
      #1;
      n_chk++; if (mif.ack !== (3'b001 << k)) $display("FAIL rr_ack%0d got=%b exp=%b", k, mif.ack, 3'b001 << k);
      else n_pass++;
      n_chk++; if (mem_paddr !== exp_pa) $display("FAIL rr_paddr%0d got=%h exp=%h", k, mem_paddr, exp_pa);
      else n_pass++;
      @(negedge clk); mif.req[k] = 1'b0; rtrn_vld = 1'b1; rtrn_id = 2'd1; #1;
      n_chk++; if (mif.rtrn_vld !== (3'b001 << k) || mif.ack !== 3'b000 || mem_req !== 1'b0)
        $display("FAIL rr_rtrn%0d got=%b ack=%b req=%b exp=%b ack=000 req=0",
                 k, mif.rtrn_vld, mif.ack, mem_req, 3'b001 << k);
      else n_pass++;
      @(negedge clk); rtrn_vld = 1'b0;
    end
    mif.req[0] = 1'b1; mif.req[1] = 1'b1; #1;
    n_chk++; if (mif.ack !== 3'b001) $display("FAIL rr_wrap got=%b exp=001", mif.ack); else n_pass++;
    @(negedge clk); clr_inputs(); rtrn_vld = 1'b1; rtrn_id = 2'd1;
    @(negedge clk); clr_inputs();
  endtask

  task automatic test_collision();
    do_reset();
    set_port(0, 32'h8000_1040, 1'b0, 3'd0, 4'b0011); mem_ack = 1'b1;
    @(negedge clk); mif.req[0] = 1'b0;
    set_port(1, 32'h8000_1058, 1'b0, 3'd0, 4'b0000);
    set_port(2, 32'h9000_0000, 1'b0, 3'd0, 4'b0000); #1;
    n_chk++; if (mif.replay !== 3'b010 || mif.ack !== 3'b000 || mem_req !== 1'b0)
      $display("FAIL coll_replay got=%b ack=%b req=%b exp=010 000 0", mif.replay, mif.ack, mem_req);
    else n_pass++;
    @(negedge clk); mif.req[1] = 1'b0; #1;
    n_chk++; if (mif.replay !== 3'b000 || mif.ack !== 3'b000)
      $display("FAIL coll_stall got=%b ack=%b exp=000 000", mif.replay, mif.ack); else n_pass++;
    @(negedge clk); mif.req[1] = 1'b1; rtrn_vld = 1'b1; rtrn_id = 2'd1; #1;
    n_chk++; if (mif.rtrn_vld !== 3'b001 || mif.replay !== 3'b010 || mif.ack !== 3'b000)
      $display("FAIL coll_same_cycle got=%b rep=%b ack=%b exp=001 010 000", mif.rtrn_vld, mif.replay, mif.ack);
    else n_pass++;
    @(negedge clk); mif.req[1] = 1'b0; rtrn_vld = 1'b0; #1;
    n_chk++; if (mif.ack !== 3'b100 || mem_paddr !== 32'h9000_0000)
      $display("FAIL coll_late_grant got=%b %h exp=100 90000000", mif.ack, mem_paddr); else n_pass++;
    @(negedge clk); mif.req[2] = 1'b0; rtrn_vld = 1'b1; #1;
    n_chk++; if (mif.rtrn_vld !== 3'b100) $display("FAIL coll_rtrn2 got=%b exp=100", mif.rtrn_vld); else n_pass++;
    @(negedge clk); clr_inputs(); #1;
    n_chk++; if (replay_cnt !== (PerfEn ? 32'd2 : 32'd0))
      $display("FAIL coll_replay_cnt got=%0d exp=%0d", replay_cnt, PerfEn ? 2 : 0); else n_pass++;
  endtask

  task automatic test_nc();
    do_reset();
    set_port(1, 32'h1000_0004, 1'b1, 3'd2, 4'b0000); mem_ack = 1'b1; #1;
    n_chk++; if (mif.ack !== 3'b010 || mem_paddr !== 32'h1000_0004 || mem_size !== 3'd2 || mem_nc !== 1'b1)
      $display("FAIL nc_req got=%b %h %0d %b exp=010 10000004 2 1", mif.ack, mem_paddr, mem_size, mem_nc);
    else n_pass++;
    @(negedge clk); mif.req = '0; mem_ack = 1'b0; rtrn_vld = 1'b1; rtrn_id = 2'd1; #1;
    n_chk++; if (mif.rtrn_vld !== 3'b010 || wr_vld !== 1'b0)
      $display("FAIL nc_rtrn got=%b wr=%b exp=010 0", mif.rtrn_vld, wr_vld); else n_pass++;
    @(negedge clk); clr_inputs();
  endtask

  task automatic test_bad_id_and_reset();
    do_reset();
    rtrn_vld = 1'b1; rtrn_id = 2'd1; #1;
    n_chk++; if (mif.rtrn_vld !== 3'b000 || wr_vld !== 1'b0)
      $display("FAIL idle_rtrn got=%b wr=%b exp=000 0", mif.rtrn_vld, wr_vld); else n_pass++;
    @(negedge clk); rtrn_vld = 1'b0;
    set_port(0, 32'h8000_1040, 1'b0, 3'd0, 4'b0000); mem_ack = 1'b1;
    @(negedge clk); mif.req = '0; mem_ack = 1'b0; rtrn_vld = 1'b1; rtrn_id = 2'd2; #1;
    n_chk++; if (mif.rtrn_vld !== 3'b000 || wr_vld !== 1'b0)
      $display("FAIL bad_id got=%b wr=%b exp=000 0", mif.rtrn_vld, wr_vld); else n_pass++;
    @(negedge clk); rtrn_vld = 1'b0; rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); rtrn_vld = 1'b1; rtrn_id = 2'd1; #1;
    n_chk++; if (mif.rtrn_vld !== 3'b000 || wr_vld !== 1'b0)
      $display("FAIL post_rst_rtrn got=%b wr=%b exp=000 0", mif.rtrn_vld, wr_vld); else n_pass++;
    @(negedge clk); clr_inputs();
  endtask

  task automatic test_lfsr_way();
    logic [3:0] exp_way [4];
    exp_way[0] = 4'b0010; exp_way[1] = 4'b0100; exp_way[2] = 4'b0010; exp_way[3] = 4'b0100;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      set_port(0, 32'h8000_2000 + 32'(k) * 32'h20, 1'b0, 3'd0, 4'b1111); mem_ack = 1'b1; #1;
      n_chk++; if (mif.ack !== 3'b001) $display("FAIL lfsr_ack%0d got=%b exp=001", k, mif.ack); else n_pass++;
      @(negedge clk); mif.req = '0; mem_ack = 1'b0; rtrn_vld = 1'b1; rtrn_id = 2'd1; #1;
      n_chk++; if (wr_vld !== 1'b1 || wr_way !== exp_way[k])
        $display("FAIL lfsr_way%0d got=%b wr=%b exp=%b", k, wr_way, wr_vld, exp_way[k]); else n_pass++;
      @(negedge clk); rtrn_vld = 1'b0;
    end
    #1;
    n_chk++; if (miss_cnt !== (PerfEn ? 32'd4 : 32'd0))
      $display("FAIL miss_cnt got=%0d exp=%0d", miss_cnt, PerfEn ? 4 : 0); else n_pass++;
  endtask

  initial begin
    clr_inputs();
    rst_n = 1'b0;
    test_reset();
    test_basic();
    test_round_robin();
    test_collision();
    test_nc();
    test_bad_id_and_reset();
    test_lfsr_way();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
